// File: rtl/cls_spi_sequencer_pkg.sv
// Shared types and constants for the PmodCLS SPI packet sequencer.
// Timing defaults assume a 100 MHz clk.
package cls_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStart,
        StWaitEnd,
        StGap,
        StNext,
        StHold,
        StRecover
    } seq_state_e;

    localparam int unsigned SsSetupCyclesDef = 100;
    localparam int unsigned ByteGapCyclesDef = 2000;
    localparam int unsigned SsHoldCyclesDef  = 100;
    localparam int unsigned TimeoutCyclesDef = 12000;
    localparam int unsigned TmrWDef          = 16;

    // PmodCLS command bytes for requesters building escape sequences.
    localparam logic [7:0] ClsEsc      = 8'h1B;
    localparam logic [7:0] ClsLBracket = 8'h5B;
    localparam logic [7:0] ClsClear    = 8'h6A;
    localparam logic [7:0] ClsHome     = 8'h48;

endpackage

// File: rtl/cls_spi_sequencer_if.sv
// Byte stream handshake from a requester into the sequencer.
interface cls_spi_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/cls_seq_timer.sv
// Loadable down-counter that saturates at zero; one instance covers every interval.
module cls_seq_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] value_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cls_spi_sequencer.sv
// Packet-level sequencer for a byte-wide SPI master talking to the PmodCLS:
// SS setup/hold, inter-byte gap, one begin pulse per byte and a WAIT_END watchdog.
module cls_spi_sequencer
    import cls_spi_sequencer_pkg::*;
#(
    parameter int unsigned SS_SETUP_CYCLES = SsSetupCyclesDef,
    parameter int unsigned BYTE_GAP_CYCLES = ByteGapCyclesDef,
    parameter int unsigned SS_HOLD_CYCLES  = SsHoldCyclesDef,
    parameter int unsigned TIMEOUT_CYCLES  = TimeoutCyclesDef,
    parameter int unsigned TMR_W           = TmrWDef
) (
    input  logic               clk,
    input  logic               rst,
    cls_spi_sequencer_if.slave tx_if,
    output logic [7:0]         send_data_o,
    output logic               begin_transmission_o,
    output logic               slave_select_o,
    input  logic               end_transmission_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_err_o
);

    seq_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             ss_q, ss_d;
    logic             begin_q, begin_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             tx_ready;
    logic             accept;

    cls_seq_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .value_i(tmr_value),
        .zero_o (tmr_zero)
    );

    assign tx_ready = (state_q == StIdle) || (state_q == StNext);
    assign accept   = tx_if.tx_valid && tx_ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        ss_d      = ss_q;
        begin_d   = 1'b0;
        done_d    = 1'b0;
        to_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d    = tx_if.tx_data;
                    last_d    = tx_if.tx_last;
                    ss_d      = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SS_SETUP_CYCLES - 1);
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                // begin_q is raised on entry so the pulse coincides with the START cycle.
                if (tmr_zero) begin
                    begin_d = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tmr_load  = 1'b1;
                tmr_value = TMR_W'(TIMEOUT_CYCLES - 1);
                state_d   = StWaitEnd;
            end
            StWaitEnd: begin
                // A completion arriving on the expiry cycle still counts as success.
                if (end_transmission_i) begin
                    tmr_load = 1'b1;
                    if (last_q) begin
                        tmr_value = TMR_W'(SS_HOLD_CYCLES - 1);
                        state_d   = StHold;
                    end else begin
                        tmr_value = TMR_W'(BYTE_GAP_CYCLES - 1);
                        state_d   = StGap;
                    end
                end else if (tmr_zero) begin
                    to_d    = 1'b1;
                    ss_d    = 1'b1;
                    state_d = StRecover;
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (accept) begin
                    data_d  = tx_if.tx_data;
                    last_d  = tx_if.tx_last;
                    begin_d = 1'b1;
                    state_d = StStart;
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    ss_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StRecover;
                end
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                ss_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            ss_q    <= 1'b1;
            begin_q <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ss_q    <= ss_d;
            begin_q <= begin_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign tx_if.tx_ready       = tx_ready;
    assign send_data_o          = data_q;
    assign begin_transmission_o = begin_q;
    assign slave_select_o       = ss_q;
    assign busy_o               = (state_q != StIdle);
    assign done_o               = done_q;
    assign timeout_err_o        = to_q;

endmodule

// File: tb/tb_cls_spi_sequencer.sv
// Randomized bench for cls_spi_sequencer: event timestamps are compared against
// cycle arithmetic derived from the interval rules of the controller.
module tb_cls_spi_sequencer;

    localparam int S = 100;
    localparam int G = 2000;
    localparam int H = 100;
    localparam int T = 12000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] send_data;
    logic       begin_tx;
    logic       ss;
    logic       end_tx;
    logic       busy;
    logic       done;
    logic       timeout_err;

    cls_spi_sequencer_if tx_if ();

    cls_spi_sequencer #(
        .SS_SETUP_CYCLES(S),
        .BYTE_GAP_CYCLES(G),
        .SS_HOLD_CYCLES (H),
        .TIMEOUT_CYCLES (T),
        .TMR_W          (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tx_if               (tx_if),
        .send_data_o         (send_data),
        .begin_transmission_o(begin_tx),
        .slave_select_o      (ss),
        .end_transmission_i  (end_tx),
        .busy_o              (busy),
        .done_o              (done),
        .timeout_err_o       (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Event monitor plus protocol invariants, sampled on the falling edge.
    int   beg_q[$];
    int   beg_dat_q[$];
    int   done_q[$];
    int   to_q[$];
    int   rise_q[$];
    int   fall_q[$];
    int   viol       = 0;
    int   ss_low_run = 0;
    logic ss_prev    = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            ss_low_run = 0;
            ss_prev    = 1'b1;
        end else begin
            if (begin_tx) begin
                beg_q.push_back(cyc);
                beg_dat_q.push_back(int'(send_data));
                if (ss || ss_low_run < S) viol++;
            end
            if (done) done_q.push_back(cyc);
            if (timeout_err) to_q.push_back(cyc);
            if (done && timeout_err) viol++;
            if (!ss && !busy) viol++;
            if (ss && !ss_prev) rise_q.push_back(cyc);
            if (!ss && ss_prev) fall_q.push_back(cyc);
            ss_low_run = ss ? 0 : ss_low_run + 1;
            ss_prev    = ss;
        end
    end

    // SPI master model: end pulse d cycles after each begin; d < 0 means never.
    int spi_dly_q[$];
    initial begin
        end_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && begin_tx) begin
                int d;
                bit ab;
                d  = (spi_dly_q.size() > 0) ? spi_dly_q.pop_front() : -1;
                ab = 1'b0;
                if (d > 0) begin
                    for (int k = 0; k < d; k++) begin
                        @(posedge clk);
                        if (rst) begin
                            ab = 1'b1;
                            break;
                        end
                    end
                    if (!ab) begin
                        #1 end_tx = 1'b1;
                        @(posedge clk);
                        #1 end_tx = 1'b0;
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] data, input logic last, input int stall,
                             output int v, output int a, output bit ok);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
        end
        tx_if.tx_data  = data;
        tx_if.tx_last  = last;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        v  = cyc;
        ok = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            if (tx_if.tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        a = cyc;
        @(posedge clk);
        #1 tx_if.tx_valid = 1'b0;
        tx_if.tx_last = 1'b0;
    endtask

    task automatic clear_events();
        beg_q.delete();
        beg_dat_q.delete();
        done_q.delete();
        to_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    logic [7:0] pkt_data[$];
    int         pkt_dly[$];
    int         pkt_stall[$];

    task automatic run_packet(input string nm);
        int  n, v, a, ma, mb, e_prev, fin, idle_c, a0;
        bit  ok, timed_out;
        int  vq[$], aq[$];
        n = pkt_data.size();
        clear_events();
        spi_dly_q = pkt_dly;
        for (int i = 0; i < n; i++) begin
            send_byte(pkt_data[i], (i == n - 1), pkt_stall[i], v, a, ok);
            if (!ok) check_eq($sformatf("%s_accept_wait%0d", nm, i), 0, 1);
            vq.push_back(v);
            aq.push_back(a);
        end
        @(negedge clk);
        for (int k = 0; k < 40000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        idle_c = cyc;
        check_eq({nm, "_idle_wait"}, busy, 0);

        e_prev    = 0;
        a0        = 0;
        fin       = 0;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) ma = vq[0];
            else ma = (vq[i] > e_prev + G + 1) ? vq[i] : e_prev + G + 1;
            if (i == 0) a0 = ma;
            mb = (i == 0) ? ma + S + 1 : ma + 1;
            check_eq($sformatf("%s_accept%0d", nm, i), aq[i], ma);
            check_eq($sformatf("%s_begin%0d", nm, i), qget(beg_q, i), mb);
            check_eq($sformatf("%s_data%0d", nm, i), qget(beg_dat_q, i), int'(pkt_data[i]));
            if (pkt_dly[i] < 0) begin
                timed_out = 1'b1;
                fin       = mb + T + 1;
                break;
            end
            e_prev = mb + pkt_dly[i];
        end
        if (!timed_out) fin = e_prev + H + 1;

        check_eq({nm, "_begin_count"}, beg_q.size(), n);
        check_eq({nm, "_ss_fall"}, qget(fall_q, 0), a0 + 1);
        check_eq({nm, "_ss_fall_count"}, fall_q.size(), 1);
        check_eq({nm, "_ss_rise"}, qget(rise_q, 0), fin);
        check_eq({nm, "_ss_rise_count"}, rise_q.size(), 1);
        check_eq({nm, "_done_count"}, done_q.size(), timed_out ? 0 : 1);
        check_eq({nm, "_timeout_count"}, to_q.size(), timed_out ? 1 : 0);
        if (timed_out) check_eq({nm, "_timeout_at"}, qget(to_q, 0), fin);
        else check_eq({nm, "_done_at"}, qget(done_q, 0), fin);
        check_eq({nm, "_busy_low_at"}, idle_c, fin + 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  v, a, n;
        bit  ok;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;
        tx_if.tx_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ss", ss, 1);
        check_eq("rst_begin", begin_tx, 0);
        check_eq("rst_send_data", send_data, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", tx_if.tx_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        pkt_data = {8'h41}; pkt_dly = {8016}; pkt_stall = {0};
        run_packet("single");

        pkt_data = {8'h1B, 8'h5B, 8'h6A, 8'h48}; pkt_dly = {150, 90, 300, 60};
        pkt_stall = {0, 0, 0, 0};
        run_packet("four");

        pkt_data = {8'hA5, 8'h5A}; pkt_dly = {100, 50};
        pkt_stall = {0, 100 + S + 1 + G + 1 + 5000};
        run_packet("stall");

        pkt_data = {8'h33}; pkt_dly = {-1}; pkt_stall = {0};
        run_packet("timeout");

        pkt_data = {8'h44}; pkt_dly = {T}; pkt_stall = {0};
        run_packet("race");

        // Reset while the second byte is in flight.
        clear_events();
        spi_dly_q = {40, 3000};
        send_byte(8'h31, 1'b0, 0, v, a, ok);
        send_byte(8'h32, 1'b0, 0, v, a, ok);
        check_eq("mid_rst_accept_ok", ok, 1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_begin_count", beg_q.size(), 2);
        check_eq("mid_rst_ss", ss, 1);
        check_eq("mid_rst_begin", begin_tx, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", tx_if.tx_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        spi_dly_q.delete();

        pkt_data = {8'h7E}; pkt_dly = {20}; pkt_stall = {0};
        run_packet("after_rst");

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            pkt_data.delete(); pkt_dly.delete(); pkt_stall.delete();
            for (int i = 0; i < n; i++) begin
                pkt_data.push_back(8'($urandom));
                pkt_dly.push_back($urandom_range(8, 200));
                pkt_stall.push_back((i == 0) ? $urandom_range(0, 20) : $urandom_range(0, 800));
            end
            run_packet($sformatf("rand%0d", r));
        end

        check_eq("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
